// File: rtl/boxcar_averager_if.sv
// Sample stream bundle for the boxcar averager: the upstream sample
// handshake and the downstream average handshake.
interface boxcar_averager_if #(
   parameter int IN_W  = 17,
   parameter int OUT_W = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;

   // Producer of samples / consumer of averages.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // The averaging block itself.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/boxcar_averager.sv
// Boxcar averager: sums N = 2^k signed samples, then presents the
// floor-shifted, saturated average until downstream takes it. One block
// at a time; upstream is stalled while an average is pending.
module boxcar_averager #(
   parameter int IN_W     = 17,
   parameter int OUT_W    = 16,
   parameter int MAX_LOG2 = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clear,
   input  logic [3:0]         log2_n,
   boxcar_averager_if.slave   bus,
   output logic               sat_sticky
);

   localparam int ACC_W = IN_W + MAX_LOG2;
   localparam int CNT_W = MAX_LOG2 + 1;
   localparam logic [3:0] MAX_EXP = 4'(MAX_LOG2);
   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   // True when the value does not fit the output range.
   function automatic logic is_sat(input logic signed [ACC_W-1:0] v);
      return (v > OUT_MAX) || (v < OUT_MIN);
   endfunction

   // Clamp a wide value into the signed output range.
   function automatic logic signed [OUT_W-1:0] sat_val(input logic signed [ACC_W-1:0] v);
      if (v > OUT_MAX)
         return OUT_MAX[OUT_W-1:0];
      else if (v < OUT_MIN)
         return OUT_MIN[OUT_W-1:0];
      else
         return v[OUT_W-1:0];
   endfunction

   state_t                  state;
   logic [3:0]              exp_q;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;
   logic signed [OUT_W-1:0] out_data_q;
   logic                    out_valid_q;

   logic                    accept;
   logic [3:0]              eff_exp;
   logic [3:0]              exp_use;
   logic signed [ACC_W-1:0] in_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] avg;
   logic [CNT_W-1:0]        cnt_next;
   logic                    last;

   assign bus.in_ready  = (state != HOLD);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // Next accumulator/count values and end-of-block detection for an accept.
   // The first sample of a block uses the live exponent; later ones the latched one.
   always_comb begin
      accept   = bus.in_valid && (state != HOLD);
      eff_exp  = (log2_n > MAX_EXP) ? MAX_EXP : log2_n;
      in_ext   = ACC_W'(bus.in_data);
      exp_use  = exp_q;
      acc_sum  = acc + in_ext;
      cnt_next = cnt + CNT_W'(1);
      if (state == IDLE) begin
         exp_use  = eff_exp;
         acc_sum  = in_ext;
         cnt_next = CNT_W'(1);
      end
      last = (cnt_next == (CNT_W'(1) << exp_use));
      avg  = acc_sum >>> exp_use;
   end

   // Block state machine: reset beats clear, clear beats both handshakes.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         exp_q       <= '0;
         acc         <= '0;
         cnt         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sat_sticky  <= 1'b0;
      end else if (clear) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         sat_sticky  <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc <= acc_sum;
                  cnt <= cnt_next;
                  if (state == IDLE)
                     exp_q <= eff_exp;
                  if (last) begin
                     state       <= HOLD;
                     out_data_q  <= sat_val(avg);
                     out_valid_q <= 1'b1;
                     if (is_sat(avg))
                        sat_sticky <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  acc         <= '0;
                  cnt         <= '0;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boxcar_averager.sv
// Bench for boxcar_averager: directed vector table, hand-written corner
// sequences, and randomized blocks against a floor-division model.
module tb_boxcar_averager;

   logic       clk = 1'b0;
   logic       rstn;
   logic       clear;
   logic [3:0] log2_n;
   logic       sat_sticky;

   boxcar_averager_if #(.IN_W(17), .OUT_W(16)) bus ();

   boxcar_averager #(.IN_W(17), .OUT_W(16), .MAX_LOG2(8)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .clear      (clear),
      .log2_n     (log2_n),
      .bus        (bus),
      .sat_sticky (sat_sticky)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit clr;
      int lg;
      int n;
      int s0, s1, s2, s3;
      int eo;
      int es;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int s);
      bus.in_valid = 1'b1;
      bus.in_data  = 17'(s);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Mean rounded toward minus infinity.
   function automatic longint floor_div(input longint sum, input longint n);
      if (sum >= 0)
         return sum / n;
      else
         return -((-sum + n - 1) / n);
   endfunction

   initial begin
      int arr [4];
      longint sum, mean, exp_out;
      int lg, k, n, s, r, hold_val, exp_sat;

      tbl[0] = '{1, 2, 4,    100,    200, 300, 400,    250, 0};
      tbl[1] = '{1, 0, 1,     -5,      0,   0,   0,     -5, 0};
      tbl[2] = '{0, 1, 2,     -1,      0,   0,   0,     -1, 0};
      tbl[3] = '{1, 0, 1,  65535,      0,   0,   0,  32767, 1};
      tbl[4] = '{0, 0, 1, -65536,      0,   0,   0, -32768, 1};
      tbl[5] = '{1, 2, 4,  65535,  65535, 65535, 65535, 32767, 1};
      tbl[6] = '{1, 1, 2,      3,      4,   0,   0,      3, 0};
      tbl[7] = '{1, 1, 2,     -3,     -4,   0,   0,     -4, 0};

      rstn          = 1'b0;
      clear         = 1'b0;
      log2_n        = 4'd0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_sat", sat_sticky, 0);
      rstn = 1'b1;
      check("rel_in_ready", bus.in_ready, 1);

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].clr)
            pulse_clear();
         log2_n = 4'(tbl[i].lg);
         arr = '{tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3};
         for (int j = 0; j < tbl[i].n; j++) begin
            check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
            send(arr[j]);
         end
         check($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
         check($sformatf("vec%0d_out_data", i), bus.out_data, tbl[i].eo);
         check($sformatf("vec%0d_sat", i), sat_sticky, tbl[i].es);
         tick();
         check($sformatf("vec%0d_done", i), bus.out_valid, 0);
      end
      pulse_clear();
      check("clear_sat", sat_sticky, 0);

      // Backpressure: average held while upstream keeps offering a sample
      bus.out_ready = 1'b0;
      log2_n = 4'd1;
      send(7);
      send(9);
      check("bp_data0", bus.out_data, 8);
      bus.in_valid = 1'b1;
      bus.in_data  = 17'(123);
      log2_n = 4'd0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_data", bus.out_data, 8);
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check("bp_held_valid", bus.out_valid, 1);
      check("bp_held_data", bus.out_data, 123);
      tick();

      // Clear mid-block overrides a simultaneous accept; new exponent next block
      log2_n = 4'd3;
      for (int j = 1; j <= 5; j++)
         send(j);
      clear = 1'b1;
      log2_n = 4'd1;
      bus.in_valid = 1'b1;
      bus.in_data  = 17'(1000);
      tick();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      check("clr_out_valid", bus.out_valid, 0);
      check("clr_in_ready", bus.in_ready, 1);
      send(10);
      check("clr_mid_valid", bus.out_valid, 0);
      send(20);
      check("clr_next_valid", bus.out_valid, 1);
      check("clr_next_data", bus.out_data, 15);
      tick();

      // Exponent change mid-block is ignored until the next block
      log2_n = 4'd1;
      send(6);
      log2_n = 4'd0;
      check("exp_mid_valid", bus.out_valid, 0);
      send(10);
      check("exp_end_valid", bus.out_valid, 1);
      check("exp_end_data", bus.out_data, 8);
      tick();

      // Reset after 3 of 4 samples
      log2_n = 4'd2;
      for (int j = 0; j < 3; j++)
         send(100);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("mrst_out_valid", bus.out_valid, 0);
      check("mrst_out_data", bus.out_data, 0);
      check("mrst_sat", sat_sticky, 0);
      check("mrst_in_ready", bus.in_ready, 1);
      for (int j = 0; j < 4; j++)
         send(8);
      check("mrst_valid", bus.out_valid, 1);
      check("mrst_data", bus.out_data, 8);
      tick();

      // Randomized blocks against the reference model
      pulse_clear();
      exp_sat = 0;
      for (int b = 0; b < 40; b++) begin
         lg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 4));
         log2_n = 4'(lg);
         k = (lg > 8) ? 8 : lg;
         n = 1 << k;
         sum = 0;
         for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 2));
            for (int g = 0; g < r; g++)
               tick();
            if ($urandom_range(0, 3) == 0)
               s = int'($urandom_range(0, 131071)) - 65536;
            else
               s = int'($urandom_range(0, 2000)) - 1000;
            send(s);
            sum += s;
            if (i == 0)
               log2_n = 4'($urandom_range(0, 15));
            if (i < n - 1)
               check("rnd_early_valid", bus.out_valid, 0);
         end
         mean = floor_div(sum, n);
         exp_out = mean;
         if (mean > 32767) exp_out = 32767;
         if (mean < -32768) exp_out = -32768;
         if (exp_out != mean) exp_sat = 1;
         check("rnd_valid", bus.out_valid, 1);
         check("rnd_data", bus.out_data, exp_out);
         check("rnd_sat", sat_sticky, exp_sat);
         hold_val = int'(exp_out);
         bus.out_ready = 1'b0;
         r = int'($urandom_range(0, 3));
         for (int c = 0; c < r; c++) begin
            tick();
            check("rnd_hold_valid", bus.out_valid, 1);
            check("rnd_hold_data", bus.out_data, hold_val);
         end
         bus.out_ready = 1'b1;
         tick();
         check("rnd_done", bus.out_valid, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/boxcar_averager.md
BOXCAR_AVERAGER -- requirements
Module: boxcar_averager

Interface
REQ-001 SHALL have parameter IN_W, default 17: input sample width, signed two's complement; matches the 17-bit adder/subtracter result it consumes.
REQ-002 SHALL have parameter OUT_W, default 16: output sample width, signed two's complement.
REQ-003 SHALL have parameter MAX_LOG2, default 8: largest averaging exponent, so N ranges 1..256.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 clear  input  1  synchronous soft clear of the block in progress.
REQ-007 log2_n  input  4  averaging exponent, N = 2^log2_n.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block can accept a sample this cycle.
REQ-010 in_data  input  IN_W  signed input sample.
REQ-011 out_valid  output  1  out_data holds a completed average.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  OUT_W  signed, saturated average.
REQ-014 sat_sticky  output  1  set once any output has saturated.

Function
REQ-015 SHALL accept an input sample only on a cycle where in_valid=1 and in_ready=1.
REQ-016 SHALL implement three states: IDLE, ACCUM and HOLD.
REQ-017 IDLE: in_ready=1; on an accepted sample SHALL latch the effective exponent, set acc=sign-extended in_data and count=1, then go to ACCUM, or directly to HOLD if N=1.
REQ-018 The effective exponent SHALL be min(log2_n, MAX_LOG2), latched only in IDLE and held constant for the whole block.
REQ-019 ACCUM: in_ready=1; each accepted sample SHALL do acc+=in_data and count+=1; the accept that brings count to N SHALL move the block to HOLD.
REQ-020 Accumulator width SHALL be IN_W+MAX_LOG2 (25 bits), signed, so it never wraps for any legal N.
REQ-021 On entry to HOLD, out_data SHALL be registered as acc arithmetically shifted right by the exponent (truncation toward minus infinity), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-022 out_valid SHALL be asserted the cycle after the N-th sample is accepted (latency 1 cycle).
REQ-023 HOLD: in_ready=0; out_valid=1; out_data SHALL be held stable until out_valid and out_ready are both high in the same cycle.
REQ-024 On that HOLD handshake the block SHALL return to IDLE with acc=0 and count=0; out_valid=0 from the next cycle.
REQ-025 Samples arriving in HOLD SHALL NOT be accepted (in_ready=0); they are not lost, because upstream holds them.
REQ-026 If saturation occurs on entry to HOLD, sat_sticky SHALL be set on the same edge that registers out_data.
REQ-027 clear=1 SHALL, at the next edge, force IDLE, acc=0, count=0, out_valid=0 and sat_sticky=0, discarding any partial block and any pending output.
REQ-028 clear SHALL override any simultaneous input or output handshake in the same cycle.
REQ-029 A change on log2_n mid-block SHALL take effect only from the next block.

Reset
REQ-030 While rstn=0 at a clock edge: state=IDLE, acc=0, count=0, out_data=0, out_valid=0, sat_sticky=0.
REQ-031 Reset SHALL take priority over clear and over both handshakes.
REQ-032 Reset asserted mid-block or in HOLD SHALL discard all partial and pending data.
REQ-033 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-034 Average: log2_n=2, samples 100, 200, 300, 400 on consecutive cycles, out_ready=1 -> out_valid one cycle after 400 is accepted, out_data=250, sat_sticky=0.
REQ-035 Pass-through and rounding: log2_n=0, in_data=-5 -> out_data=-5 next cycle; then log2_n=1 with samples -1, 0 -> out_data=-1 (floor).
REQ-036 Saturation: log2_n=0, in_data=65535 -> out_data=32767 and sat_sticky=1; then in_data=-65536 -> out_data=-32768; sat_sticky stays 1 until clear.
REQ-037 Backpressure: out_ready=0 for 3 cycles in HOLD -> out_valid=1, in_ready=0 and out_data stable throughout; out_ready=1 -> IDLE next cycle.
REQ-038 Clear/exponent: log2_n=3, accept 5 samples, pulse clear, change log2_n to 1 mid-block -> no output; next block averages 2 samples.
REQ-039 Reset mid-block: rstn=0 for 1 cycle after 3 of 4 samples -> all outputs zero and in_ready=1 after release; next 4 samples of 8 -> out_data=8.
